// File: rtl/la_stream_bridge.sv
// Bridge between the logic-analyzer toggle/ack host interface and a valid/ready core.
// Input and output words are buffered in small FIFOs, with occupancy and word counters.
module la_stream_bridge #(
  parameter int IN_W      = 12,
  parameter int OUT_W     = 24,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [IN_W-1:0]              host_in_dat,
  input  logic                         host_in_tgl,
  output logic                         host_in_ack,
  output logic [OUT_W-1:0]             host_out_dat,
  output logic                         host_out_tgl,
  input  logic                         host_out_ack,
  input  logic                         flush,
  output logic [IN_W-1:0]              core_in_dat,
  output logic                         core_in_vld,
  input  logic                         core_in_rdy,
  input  logic [OUT_W-1:0]             core_out_dat,
  input  logic                         core_out_vld,
  output logic                         core_out_rdy,
  output logic [$clog2(IN_DEPTH):0]    in_level,
  output logic [$clog2(OUT_DEPTH):0]   out_level,
  output logic [CNT_W-1:0]             words_out
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam logic [IN_AW:0]  IN_FULL  = (IN_AW+1)'(IN_DEPTH);
  localparam logic [OUT_AW:0] OUT_FULL = (OUT_AW+1)'(OUT_DEPTH);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t              state;
  logic [IN_W-1:0]     in_mem  [IN_DEPTH];
  logic [OUT_W-1:0]    out_mem [OUT_DEPTH];
  logic [IN_AW-1:0]    in_wr, in_rd;
  logic [OUT_AW-1:0]   out_wr, out_rd;
  logic                in_push, in_pop, out_push, out_pop, consume;

  // A full input FIFO leaves the host offer pending, even if the core pops this cycle.
  assign in_push      = (host_in_tgl != host_in_ack) && (in_level != IN_FULL);
  assign in_pop       = core_in_vld && core_in_rdy;
  assign core_in_vld  = (in_level != '0);
  assign core_in_dat  = in_mem[in_rd];

  assign core_out_rdy = !wb_rst_i && (out_level != OUT_FULL);
  assign out_push     = core_out_vld && core_out_rdy;
  assign out_pop      = (state == IDLE) && (out_level != '0) && !flush;
  assign consume      = (state == PRESENT) && (host_out_ack == host_out_tgl);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      in_wr       <= '0;
      in_rd       <= '0;
      in_level    <= '0;
      host_in_ack <= 1'b0;
      for (int i = 0; i < IN_DEPTH; i++) in_mem[i] <= '0;
    end else if (flush) begin
      in_wr       <= '0;
      in_rd       <= '0;
      in_level    <= '0;
      host_in_ack <= host_in_tgl;
    end else begin
      if (in_push) begin
        in_mem[in_wr] <= host_in_dat;
        in_wr         <= in_wr + 1'b1;
        host_in_ack   <= ~host_in_ack;
      end
      if (in_pop) in_rd <= in_rd + 1'b1;
      if (in_push && !in_pop)      in_level <= in_level + 1'b1;
      else if (!in_push && in_pop) in_level <= in_level - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_wr    <= '0;
      out_rd    <= '0;
      out_level <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) out_mem[i] <= '0;
    end else if (flush) begin
      out_wr    <= '0;
      out_rd    <= '0;
      out_level <= '0;
    end else begin
      if (out_push) begin
        out_mem[out_wr] <= core_out_dat;
        out_wr          <= out_wr + 1'b1;
      end
      if (out_pop) out_rd <= out_rd + 1'b1;
      if (out_push && !out_pop)      out_level <= out_level + 1'b1;
      else if (!out_push && out_pop) out_level <= out_level - 1'b1;
    end
  end

  // Presentation FSM; flush leaves a presented word in place so the host can still take it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      host_out_tgl <= 1'b0;
      host_out_dat <= '0;
      words_out    <= '0;
    end else begin
      if (state == IDLE) begin
        if (out_pop) begin
          host_out_dat <= out_mem[out_rd];
          host_out_tgl <= ~host_out_tgl;
          state        <= PRESENT;
        end
      end else if (consume) begin
        state <= IDLE;
      end
      if (flush)        words_out <= consume ? CNT_W'(1) : '0;
      else if (consume) words_out <= words_out + 1'b1;
    end
  end

endmodule
